tmds_channel_encoder: RTL and testbench

//  One TMDS channel encoder: 8b data / 2b control / guard band -> 10b symbol.

---
 rtl/tmds_channel_encoder_if.sv | 21 ++
 rtl/tmds_channel_encoder.sv | 149 ++++++++++++++
 tb/tb_tmds_channel_encoder.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tmds_channel_encoder_if.sv
// Pixel-side bus of one TMDS lane: symbol request in (ce/mode/d/c) and encoded
// symbol plus status out, with modports for the timing generator and the encoder.
interface tmds_channel_encoder_if;
  logic       ce;
  logic [1:0] mode;
  logic [7:0] d;
  logic [1:0] c;
  logic [9:0] tmds;
  logic       tmds_valid;
  logic [4:0] disparity;

  modport master (
    output ce, mode, d, c,
    input  tmds, tmds_valid, disparity
  );

  modport slave (
    input  ce, mode, d, c,
    output tmds, tmds_valid, disparity
  );
endinterface

// File: rtl/tmds_channel_encoder.sv
// One TMDS channel encoder: 8b video / 2b control / guard band -> 10b symbol,
// three pipeline stages (decision, transition minimisation, DC balance).
module tmds_channel_encoder #(
  parameter int unsigned CHANNEL = 0
) (
  input logic                    clk,
  input logic                    rst_n,
  tmds_channel_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_CTRL     = 2'b00,
    MODE_VIDEO    = 2'b01,
    MODE_GUARD    = 2'b10,
    MODE_CTRL_ALT = 2'b11
  } mode_e;

  localparam logic [9:0] CTRL_00    = 10'b1101010100;
  localparam logic [9:0] CTRL_01    = 10'b0010101011;
  localparam logic [9:0] CTRL_10    = 10'b0101010100;
  localparam logic [9:0] CTRL_11    = 10'b1010101011;
  localparam logic [9:0] GUARD_CODE = (CHANNEL == 1) ? 10'b0100110011 : 10'b1011001100;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [8:0] minimise(input logic [7:0] v, input logic inv);
    logic [8:0] q;
    q    = 9'd0;
    q[0] = v[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = inv ? ~(q[i-1] ^ v[i]) : (q[i-1] ^ v[i]);
    end
    q[8] = ~inv;
    return q;
  endfunction

  // Stage 1: captured inputs and XOR/XNOR decision
  logic [7:0] d1_q, d1_d;
  logic [1:0] c1_q, c1_d;
  mode_e      mode1_q, mode1_d;
  logic       invert1_q, invert1_d;

  // Stage 2: transition-minimised word
  logic [8:0] qm2_q, qm2_d;
  logic [1:0] c2_q, c2_d;
  mode_e      mode2_q, mode2_d;

  // Stage 3: output symbol, running disparity, pipeline fill count
  logic [9:0]        tmds_q, tmds_d;
  logic signed [4:0] cnt_q, cnt_d;
  logic [1:0]        fill_q, fill_d;

  logic [3:0]        n1_in;
  logic [3:0]        n1_qm, n0_qm;
  logic signed [4:0] bal;

  always_comb begin
    n1_in     = ones8(bus.d);
    invert1_d = (n1_in > 4'd4) || ((n1_in == 4'd4) && !bus.d[0]);
    d1_d      = bus.d;
    c1_d      = bus.c;
    mode1_d   = mode_e'(bus.mode);
  end

  always_comb begin
    qm2_d   = minimise(d1_q, invert1_q);
    c2_d    = c1_q;
    mode2_d = mode1_q;
  end

  // NOTE: every always_comb output gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    tmds_d = tmds_q;
    cnt_d  = cnt_q;
    n1_qm  = ones8(qm2_q[7:0]);
    n0_qm  = 4'd8 - n1_qm;
    bal    = $signed({1'b0, n1_qm}) - $signed({1'b0, n0_qm});

    unique case (mode2_q)
      MODE_VIDEO: begin
        if ((cnt_q == 5'sd0) || (n1_qm == n0_qm)) begin
          tmds_d = {~qm2_q[8], qm2_q[8], qm2_q[8] ? qm2_q[7:0] : ~qm2_q[7:0]};
          cnt_d  = qm2_q[8] ? (cnt_q + bal) : (cnt_q - bal);
        end else if ((!cnt_q[4] && (n1_qm > n0_qm)) || (cnt_q[4] && (n0_qm > n1_qm))) begin
          // Disparity already leans the same way as this word: send it inverted.
          tmds_d = {1'b1, qm2_q[8], ~qm2_q[7:0]};
          cnt_d  = cnt_q + (qm2_q[8] ? 5'sd2 : 5'sd0) - bal;
        end else begin
          tmds_d = {1'b0, qm2_q[8], qm2_q[7:0]};
          cnt_d  = cnt_q + bal - (qm2_q[8] ? 5'sd0 : 5'sd2);
        end
      end
      MODE_GUARD: begin
        tmds_d = GUARD_CODE;
        cnt_d  = 5'sd0;
      end
      default: begin
        unique case (c2_q)
          2'b00: tmds_d = CTRL_00;
          2'b01: tmds_d = CTRL_01;
          2'b10: tmds_d = CTRL_10;
          2'b11: tmds_d = CTRL_11;
        endcase
        cnt_d = 5'sd0;
      end
    endcase

    fill_d = (fill_q == 2'd3) ? fill_q : (fill_q + 2'd1);
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples the previous stage's old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_q      <= 8'd0;
      c1_q      <= 2'd0;
      mode1_q   <= MODE_CTRL;
      invert1_q <= 1'b0;
      qm2_q     <= 9'd0;
      c2_q      <= 2'd0;
      mode2_q   <= MODE_CTRL;
      tmds_q    <= CTRL_00;
      cnt_q     <= 5'sd0;
      fill_q    <= 2'd0;
    end else if (bus.ce) begin
      d1_q      <= d1_d;
      c1_q      <= c1_d;
      mode1_q   <= mode1_d;
      invert1_q <= invert1_d;
      qm2_q     <= qm2_d;
      c2_q      <= c2_d;
      mode2_q   <= mode2_d;
      tmds_q    <= tmds_d;
      cnt_q     <= cnt_d;
      fill_q    <= fill_d;
    end
  end

  assign bus.tmds       = tmds_q;
  assign bus.tmds_valid = (fill_q == 2'd3);
  assign bus.disparity  = cnt_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Directed and model-checked bench for tmds_channel_encoder; lanes 0 and 1 run
// side by side on the same input stream to cover both guard-band codes.
module tb_tmds_channel_encoder;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  tmds_channel_encoder_if bus0();
  tmds_channel_encoder_if bus1();

  assign bus1.ce   = bus0.ce;
  assign bus1.mode = bus0.mode;
  assign bus1.d    = bus0.d;
  assign bus1.c    = bus0.c;

  tmds_channel_encoder #(.CHANNEL(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  tmds_channel_encoder #(.CHANNEL(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  task automatic drive(input logic [1:0] m, input logic [7:0] dd, input logic [1:0] cc);
    bus0.mode = m;
    bus0.d    = dd;
    bus0.c    = cc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_ctrl();
    bus0.ce = 1'b1;
    drive(2'b00, 8'h00, 2'b00);
    repeat (3) step();
  endtask

  task automatic model_encode(input logic [1:0] m, input logic [7:0] dd, input logic [1:0] cc,
                              input int cnt_in, output int cnt_out, output logic [9:0] sym);
    int         ones_d;
    int         n1;
    int         n0;
    logic       use_xnor;
    logic [8:0] qm;
    cnt_out = 0;
    sym     = 10'h354;
    if (m == 2'b01) begin
      ones_d   = $countones(dd);
      use_xnor = (ones_d > 4) || (ones_d == 4 && dd[0] == 1'b0);
      qm       = '0;
      qm[0]    = dd[0];
      for (int i = 1; i < 8; i++) qm[i] = use_xnor ? (qm[i-1] ~^ dd[i]) : (qm[i-1] ^ dd[i]);
      qm[8] = !use_xnor;
      n1    = $countones(qm[7:0]);
      n0    = 8 - n1;
      if (cnt_in == 0 || n1 == n0) begin
        sym     = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        cnt_out = cnt_in + (qm[8] ? (n1 - n0) : (n0 - n1));
      end else if ((cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1)) begin
        sym     = {1'b1, qm[8], ~qm[7:0]};
        cnt_out = cnt_in + 2 * int'(qm[8]) + (n0 - n1);
      end else begin
        sym     = {1'b0, qm[8], qm[7:0]};
        cnt_out = cnt_in + (n1 - n0) - (qm[8] ? 0 : 2);
      end
    end else if (m == 2'b10) begin
      sym = 10'h2CC;
    end else begin
      case (cc)
        2'b00:   sym = 10'h354;
        2'b01:   sym = 10'h0AB;
        2'b10:   sym = 10'h154;
        default: sym = 10'h2AB;
      endcase
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus0.ce = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(2'($urandom_range(0, 3)), 8'($urandom), 2'($urandom_range(0, 3)));
      step();
      total++;
      if (bus0.tmds !== 10'h354 || bus0.tmds_valid !== 1'b0 || bus0.disparity !== 5'd0) begin
        bad++;
        $display("FAIL reset_hold: tmds=%h valid=%b disp=%h, want 354/0/00",
                 bus0.tmds, bus0.tmds_valid, bus0.disparity);
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      drive(2'b01, 8'($urandom), 2'b00);
      step();
      total++;
      if (bus0.tmds_valid !== (e == 3)) begin
        bad++;
        $display("FAIL reset_valid edge %0d: valid=%b, want %b", e, bus0.tmds_valid, (e == 3));
      end
      if (e < 3) begin
        total++;
        if (bus0.tmds !== 10'h354) begin
          bad++;
          $display("FAIL reset_drain edge %0d: tmds=%h, want 354", e, bus0.tmds);
        end
      end
    end
  endtask

  task automatic test_latency();
    flush_ctrl();
    drive(2'b01, 8'h00, 2'b00);
    step();
    drive(2'b00, 8'h00, 2'b00);
    for (int e = 1; e <= 3; e++) begin
      logic [9:0] exp_t;
      logic [4:0] exp_p;
      exp_t = (e == 2) ? 10'h100 : 10'h354;
      exp_p = (e == 2) ? 5'b11000 : 5'b00000;
      step();
      total++;
      if (bus0.tmds !== exp_t || bus0.disparity !== exp_p) begin
        bad++;
        $display("FAIL latency edge k+%0d: tmds=%h disp=%b, want %h/%b",
                 e + 1, bus0.tmds, bus0.disparity, exp_t, exp_p);
      end
    end
  endtask

  task automatic test_balance();
    logic [9:0] exp_t [3] = '{10'h100, 10'h3FF, 10'h354};
    logic [4:0] exp_p [3] = '{5'b11000, 5'b00010, 5'b00000};
    flush_ctrl();
    drive(2'b01, 8'h00, 2'b00);
    step();
    step();
    drive(2'b00, 8'h00, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus0.tmds !== exp_t[i] || bus0.disparity !== exp_p[i]) begin
        bad++;
        $display("FAIL balance sym %0d: tmds=%h disp=%b, want %h/%b",
                 i, bus0.tmds, bus0.disparity, exp_t[i], exp_p[i]);
      end
    end
  endtask

  task automatic test_invert();
    logic [7:0] vec_d [2] = '{8'hFF, 8'h55};
    logic [9:0] exp_t [2] = '{10'h200, 10'h133};
    logic [4:0] exp_p [2] = '{5'b11000, 5'b00000};
    for (int i = 0; i < 2; i++) begin
      flush_ctrl();
      drive(2'b01, vec_d[i], 2'b00);
      step();
      drive(2'b00, 8'h00, 2'b00);
      step();
      step();
      total++;
      if (bus0.tmds !== exp_t[i] || bus0.disparity !== exp_p[i]) begin
        bad++;
        $display("FAIL invert d=%h: tmds=%h disp=%b, want %h/%b",
                 vec_d[i], bus0.tmds, bus0.disparity, exp_t[i], exp_p[i]);
      end
    end
  endtask

  task automatic test_control_guard();
    logic [1:0] in_m  [9] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b10, 2'b01, 2'b10, 2'b01};
    logic [1:0] in_c  [9] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [9:0] exp0  [9] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB, 10'h0AB, 10'h2CC, 10'h100, 10'h2CC, 10'h100};
    logic [9:0] exp1  [9] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB, 10'h0AB, 10'h133, 10'h100, 10'h133, 10'h100};
    logic [4:0] exp_p [9] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b11000, 5'd0, 5'b11000};
    flush_ctrl();
    for (int i = 0; i < 11; i++) begin
      if (i < 9) drive(in_m[i], 8'h00, in_c[i]);
      else       drive(2'b00, 8'h00, 2'b00);
      step();
      if (i >= 2) begin
        total++;
        if (bus0.tmds !== exp0[i-2] || bus1.tmds !== exp1[i-2] || bus0.disparity !== exp_p[i-2]) begin
          bad++;
          $display("FAIL ctrl_guard sym %0d: ch0=%h ch1=%h disp=%b, want %h/%h/%b",
                   i - 2, bus0.tmds, bus1.tmds, bus0.disparity, exp0[i-2], exp1[i-2], exp_p[i-2]);
        end
      end
    end
  endtask

  task automatic test_ce_stall();
    flush_ctrl();
    drive(2'b01, 8'h00, 2'b00);
    step();
    bus0.ce = 1'b0;
    drive(2'b00, 8'h00, 2'b01);
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus0.tmds !== 10'h354 || bus0.disparity !== 5'd0 || bus0.tmds_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold_a %0d: tmds=%h disp=%b valid=%b, want 354/00000/1",
                 i, bus0.tmds, bus0.disparity, bus0.tmds_valid);
      end
    end
    bus0.ce = 1'b1;
    drive(2'b00, 8'h00, 2'b00);
    step();
    total++;
    if (bus0.tmds !== 10'h354) begin
      bad++;
      $display("FAIL stall_resume_ctrl: tmds=%h, want 354", bus0.tmds);
    end
    bus0.ce = 1'b0;
    step();
    bus0.ce = 1'b1;
    step();
    bus0.ce = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (bus0.tmds !== 10'h100 || bus0.disparity !== 5'b11000) begin
        bad++;
        $display("FAIL stall_hold_b %0d: tmds=%h disp=%b, want 100/11000",
                 i, bus0.tmds, bus0.disparity);
      end
    end
    bus0.ce = 1'b1;
  endtask

  task automatic test_random_stall();
    logic [1:0] s1_m, s2_m, out_m, r_m;
    logic [7:0] s1_d, s2_d, r_d;
    logic [1:0] s1_c, s2_c, r_c;
    logic [9:0] m_tmds, sym, exp1;
    int         m_cnt, nxt_cnt, m_fill, accepted, cycles, sel;
    logic       r_ce;

    // Mid-stream reset: load a non-idle symbol, then drop rst_n between edges.
    flush_ctrl();
    drive(2'b01, 8'h00, 2'b00);
    repeat (3) step();
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus0.tmds !== 10'h354 || bus0.tmds_valid !== 1'b0 || bus0.disparity !== 5'd0) begin
      bad++;
      $display("FAIL midstream_reset: tmds=%h valid=%b disp=%h, want 354/0/00",
               bus0.tmds, bus0.tmds_valid, bus0.disparity);
    end
    step();
    rst_n = 1'b1;

    s1_m = 2'b00; s1_d = 8'h00; s1_c = 2'b00;
    s2_m = 2'b00; s2_d = 8'h00; s2_c = 2'b00;
    out_m = 2'b00; m_tmds = 10'h354; m_cnt = 0; m_fill = 0;
    accepted = 0;
    cycles   = 0;
    while (accepted < 10000 && cycles < 20000) begin
      r_ce = ($urandom_range(0, 9) >= 3);
      sel  = int'($urandom_range(0, 9));
      r_d  = 8'($urandom);
      r_c  = 2'($urandom_range(0, 3));
      r_m  = (sel <= 5) ? 2'b01 : (sel == 6) ? 2'b10 : (sel == 7) ? 2'b11 : 2'b00;
      bus0.ce = r_ce;
      drive(r_m, r_d, r_c);
      step();
      cycles++;
      if (r_ce) begin
        accepted++;
        model_encode(s2_m, s2_d, s2_c, m_cnt, nxt_cnt, sym);
        m_tmds = sym;
        m_cnt  = nxt_cnt;
        out_m  = s2_m;
        s2_m = s1_m; s2_d = s1_d; s2_c = s1_c;
        s1_m = r_m;  s1_d = r_d;  s1_c = r_c;
        if (m_fill < 3) m_fill++;
      end
      exp1 = (out_m == 2'b10) ? 10'h133 : m_tmds;
      total++;
      if (bus0.tmds !== m_tmds || bus1.tmds !== exp1 || bus0.disparity !== 5'(m_cnt)
          || bus0.tmds_valid !== (m_fill == 3)) begin
        bad++;
        $display("FAIL random cyc %0d: ch0=%h ch1=%h disp=%h valid=%b, want %h/%h/%h/%b",
                 cycles, bus0.tmds, bus1.tmds, bus0.disparity, bus0.tmds_valid,
                 m_tmds, exp1, 5'(m_cnt), (m_fill == 3));
      end
      if (out_m == 2'b01) begin
        total++;
        if ($signed(bus0.disparity) > 5'sd8 || $signed(bus0.disparity) < -5'sd8) begin
          bad++;
          $display("FAIL random_bound cyc %0d: disp=%0d, want within +-8",
                   cycles, $signed(bus0.disparity));
        end
      end
    end
    total++;
    if (accepted < 10000) begin
      bad++;
      $display("FAIL random_budget: accepted=%0d, want 10000 within 20000 cycles", accepted);
    end
    bus0.ce = 1'b1;
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    total = 0;
    bad   = 0;
    bus0.ce = 1'b1;
    drive(2'b00, 8'h00, 2'b00);
    test_reset();
    test_latency();
    test_balance();
    test_invert();
    test_control_guard();
    test_ce_stall();
    test_random_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
